timer_csr: RTL and testbench

AXI4-Lite slave register bank that configures and monitors the two-channel `timer_counter` datapath. It holds the control, load and compare registers that drive the counter inputs, and returns the live counter values on read. It latches counter `done` pulses into sticky, write-1-to-clear status bits and combines them with per-channel enables into a single interrupt line. It sits between the system AXI4-Lite interconnect and `timer_counter`.

---
 rtl/timer_csr_if.sv | 38 +++
 rtl/timer_csr.sv | 254 +++++++++++++++++++++++++
 tb/tb_timer_csr.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_csr_if.sv
// rtl/timer_csr_if.sv - AXI4-Lite bus bundle for the timer_csr register bank
// Ports (slave view):
//   aw*  write address  (awaddr, awvalid in; awready out)
//   w*   write data     (wdata, wstrb, wvalid in; wready out)
//   b*   write response (bresp, bvalid out; bready in)
//   ar*  read address   (araddr, arvalid in; arready out)
//   r*   read data      (rdata, rresp, rvalid out; rready in)
interface timer_csr_if #(
   parameter int ADDR_WIDTH = 6
);
   logic [ADDR_WIDTH-1:0] awaddr;
   logic                  awvalid;
   logic                  awready;
   logic [31:0]           wdata;
   logic [3:0]            wstrb;
   logic                  wvalid;
   logic                  wready;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic                  arvalid;
   logic                  arready;
   logic [31:0]           rdata;
   logic [1:0]            rresp;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/timer_csr.sv
// rtl/timer_csr.sv - AXI4-Lite control/status register bank for the two-channel timer_counter
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   s_axi                 AXI4-Lite slave (timer_csr_if.slave)
//   o_cnt0_*, o_cnt1_*    counter control bits and load/compare values
//   i_cnt0_done/_value    counter 0 done pulse and live value
//   i_cnt1_done/_value    counter 1 done pulse and live value
//   o_irq                 registered level interrupt, |(IRQ_STATUS & IRQ_ENABLE)
module timer_csr #(
   parameter int ADDR_WIDTH = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   timer_csr_if.slave  s_axi,
   output logic        o_cnt0_en,
   output logic        o_cnt0_reload,
   output logic        o_cnt0_count_up,
   output logic        o_cnt1_en,
   output logic        o_cnt1_reload,
   output logic        o_cnt1_count_up,
   output logic        o_cnt1_src,
   output logic [31:0] o_cnt0_load_value,
   output logic [31:0] o_cnt0_compare_value,
   output logic [31:0] o_cnt1_load_value,
   output logic [31:0] o_cnt1_compare_value,
   input  logic        i_cnt0_done,
   input  logic        i_cnt1_done,
   input  logic [31:0] i_cnt0_value,
   input  logic [31:0] i_cnt1_value,
   output logic        o_irq
);

   localparam logic [3:0]  OFF_CTRL       = 4'h0;
   localparam logic [3:0]  OFF_CNT0_LOAD  = 4'h1;
   localparam logic [3:0]  OFF_CNT0_CMP   = 4'h2;
   localparam logic [3:0]  OFF_CNT1_LOAD  = 4'h3;
   localparam logic [3:0]  OFF_CNT1_CMP   = 4'h4;
   localparam logic [3:0]  OFF_CNT0_VALUE = 4'h5;
   localparam logic [3:0]  OFF_CNT1_VALUE = 4'h6;
   localparam logic [3:0]  OFF_IRQ_STATUS = 4'h7;
   localparam logic [3:0]  OFF_IRQ_ENABLE = 4'h8;
   localparam logic [31:0] CTRL_MASK      = 32'h0000_0F07;
   localparam logic [1:0]  RESP_OKAY      = 2'b00;
   localparam logic [1:0]  RESP_SLVERR    = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_COLLECT, W_RESP} wr_state_t;
   typedef enum logic {R_IDLE, R_DATA} rd_state_t;

   wr_state_t   wr_state, wr_state_nxt;
   rd_state_t   rd_state, rd_state_nxt;

   // Holds every ready low for the first cycle after reset release.
   logic        ready_en;

   logic        aw_held, w_held;
   logic [3:0]  aw_off_q;
   logic [31:0] w_data_q;
   logic [3:0]  w_strb_q;
   logic [1:0]  bresp_q;
   logic        wr_commit;
   logic        aw_ready_c, w_ready_c, ar_ready_c;
   logic        aw_hs, w_hs, ar_hs;

   logic [31:0] rdata_q;
   logic [1:0]  rresp_q;
   logic [31:0] rd_data;
   logic        rd_err;

   logic [31:0] ctrl_q, load0_q, cmp0_q, load1_q, cmp1_q;
   logic [1:0]  irq_status_q, irq_enable_q, irq_clr;
   logic        irq_q;

   // Byte-address lanes below the register word are don't-care.
   logic        unused_addr_bits;
   assign unused_addr_bits = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0]};

   function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[i*8 +: 8] = strb[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
      end
      return res;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ready_en <= 1'b0;
      else        ready_en <= 1'b1;
   end

   // ---------------- write path ----------------
   assign aw_ready_c = ready_en && !aw_held && (wr_state != W_RESP);
   assign w_ready_c  = ready_en && !w_held  && (wr_state != W_RESP);
   assign aw_hs      = s_axi.awvalid && aw_ready_c;
   assign w_hs       = s_axi.wvalid  && w_ready_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wr_state <= W_IDLE;
      else        wr_state <= wr_state_nxt;
   end

   // The commit happens once both halves sit in their buffers, so the
   // register update always lands one edge after the later handshake.
   always_comb begin
      wr_state_nxt = wr_state;
      wr_commit    = 1'b0;
      case (wr_state)
         W_IDLE, W_COLLECT: begin
            if (aw_held && w_held) begin
               wr_commit    = 1'b1;
               wr_state_nxt = W_RESP;
            end else if (aw_held || w_held || aw_hs || w_hs) begin
               wr_state_nxt = W_COLLECT;
            end
         end
         W_RESP: begin
            if (s_axi.bready) wr_state_nxt = W_IDLE;
         end
         default: wr_state_nxt = W_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_held  <= 1'b0;
         w_held   <= 1'b0;
         aw_off_q <= 4'h0;
         w_data_q <= 32'h0;
         w_strb_q <= 4'h0;
         bresp_q  <= RESP_OKAY;
      end else if (wr_commit) begin
         aw_held <= 1'b0;
         w_held  <= 1'b0;
         bresp_q <= (aw_off_q <= OFF_IRQ_ENABLE) ? RESP_OKAY : RESP_SLVERR;
      end else begin
         if (aw_hs) begin
            aw_held  <= 1'b1;
            aw_off_q <= s_axi.awaddr[5:2];
         end
         if (w_hs) begin
            w_held   <= 1'b1;
            w_data_q <= s_axi.wdata;
            w_strb_q <= s_axi.wstrb;
         end
      end
   end

   assign s_axi.awready = aw_ready_c;
   assign s_axi.wready  = w_ready_c;
   assign s_axi.bvalid  = (wr_state == W_RESP);
   assign s_axi.bresp   = bresp_q;

   // ---------------- register file ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q       <= 32'h0;
         load0_q      <= 32'h0;
         cmp0_q       <= 32'h0;
         load1_q      <= 32'h0;
         cmp1_q       <= 32'h0;
         irq_enable_q <= 2'b00;
      end else if (wr_commit) begin
         case (aw_off_q)
            OFF_CTRL:       ctrl_q  <= apply_strb(ctrl_q, w_data_q, w_strb_q) & CTRL_MASK;
            OFF_CNT0_LOAD:  load0_q <= apply_strb(load0_q, w_data_q, w_strb_q);
            OFF_CNT0_CMP:   cmp0_q  <= apply_strb(cmp0_q, w_data_q, w_strb_q);
            OFF_CNT1_LOAD:  load1_q <= apply_strb(load1_q, w_data_q, w_strb_q);
            OFF_CNT1_CMP:   cmp1_q  <= apply_strb(cmp1_q, w_data_q, w_strb_q);
            OFF_IRQ_ENABLE: if (w_strb_q[0]) irq_enable_q <= w_data_q[1:0];
            default: ;
         endcase
      end
   end

   // W1C on byte lane 0; a done pulse in the same cycle outranks the clear.
   assign irq_clr = (wr_commit && (aw_off_q == OFF_IRQ_STATUS) && w_strb_q[0])
                    ? w_data_q[1:0] : 2'b00;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_status_q <= 2'b00;
         irq_q        <= 1'b0;
      end else begin
         irq_status_q <= (irq_status_q & ~irq_clr) | {i_cnt1_done, i_cnt0_done};
         irq_q        <= |(irq_status_q & irq_enable_q);
      end
   end

   // ---------------- read path ----------------
   assign ar_ready_c = ready_en && (rd_state == R_IDLE);
   assign ar_hs      = s_axi.arvalid && ar_ready_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_state <= R_IDLE;
      else        rd_state <= rd_state_nxt;
   end

   always_comb begin
      rd_state_nxt = rd_state;
      case (rd_state)
         R_IDLE: if (ar_hs) rd_state_nxt = R_DATA;
         R_DATA: if (s_axi.rready) rd_state_nxt = R_IDLE;
         default: rd_state_nxt = R_IDLE;
      endcase
   end

   always_comb begin
      rd_data = 32'h0;
      rd_err  = 1'b0;
      case (s_axi.araddr[5:2])
         OFF_CTRL:       rd_data = ctrl_q;
         OFF_CNT0_LOAD:  rd_data = load0_q;
         OFF_CNT0_CMP:   rd_data = cmp0_q;
         OFF_CNT1_LOAD:  rd_data = load1_q;
         OFF_CNT1_CMP:   rd_data = cmp1_q;
         OFF_CNT0_VALUE: rd_data = i_cnt0_value;
         OFF_CNT1_VALUE: rd_data = i_cnt1_value;
         OFF_IRQ_STATUS: rd_data = {30'h0, irq_status_q};
         OFF_IRQ_ENABLE: rd_data = {30'h0, irq_enable_q};
         default:        rd_err  = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= 32'h0;
         rresp_q <= RESP_OKAY;
      end else if (ar_hs) begin
         rdata_q <= rd_data;
         rresp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end
   end

   assign s_axi.arready = ar_ready_c;
   assign s_axi.rvalid  = (rd_state == R_DATA);
   assign s_axi.rdata   = rdata_q;
   assign s_axi.rresp   = rresp_q;

   // ---------------- counter-facing outputs ----------------
   assign o_cnt0_en            = ctrl_q[0];
   assign o_cnt0_reload        = ctrl_q[1];
   assign o_cnt0_count_up      = ctrl_q[2];
   assign o_cnt1_en            = ctrl_q[8];
   assign o_cnt1_reload        = ctrl_q[9];
   assign o_cnt1_count_up      = ctrl_q[10];
   assign o_cnt1_src           = ctrl_q[11];
   assign o_cnt0_load_value    = load0_q;
   assign o_cnt0_compare_value = cmp0_q;
   assign o_cnt1_load_value    = load1_q;
   assign o_cnt1_compare_value = cmp1_q;
   assign o_irq                = irq_q;

endmodule

// File: tb/tb_timer_csr.sv
// tb/tb_timer_csr.sv - scoreboard testbench for timer_csr
module tb_timer_csr;

   logic tb_clk = 1'b0;
   always #5 tb_clk = ~tb_clk;

   logic        rst_n;
   logic        o_cnt0_en, o_cnt0_reload, o_cnt0_count_up;
   logic        o_cnt1_en, o_cnt1_reload, o_cnt1_count_up, o_cnt1_src;
   logic [31:0] o_cnt0_load_value, o_cnt0_compare_value;
   logic [31:0] o_cnt1_load_value, o_cnt1_compare_value;
   logic        i_cnt0_done, i_cnt1_done;
   logic [31:0] i_cnt0_value, i_cnt1_value;
   logic        o_irq;

   timer_csr_if #(.ADDR_WIDTH(6)) s_axi ();

   timer_csr #(.ADDR_WIDTH(6)) dut (
      .clk                  (tb_clk),
      .rst_n                (rst_n),
      .s_axi                (s_axi),
      .o_cnt0_en            (o_cnt0_en),
      .o_cnt0_reload        (o_cnt0_reload),
      .o_cnt0_count_up      (o_cnt0_count_up),
      .o_cnt1_en            (o_cnt1_en),
      .o_cnt1_reload        (o_cnt1_reload),
      .o_cnt1_count_up      (o_cnt1_count_up),
      .o_cnt1_src           (o_cnt1_src),
      .o_cnt0_load_value    (o_cnt0_load_value),
      .o_cnt0_compare_value (o_cnt0_compare_value),
      .o_cnt1_load_value    (o_cnt1_load_value),
      .o_cnt1_compare_value (o_cnt1_compare_value),
      .i_cnt0_done          (i_cnt0_done),
      .i_cnt1_done          (i_cnt1_done),
      .i_cnt0_value         (i_cnt0_value),
      .i_cnt1_value         (i_cnt1_value),
      .o_irq                (o_irq)
   );

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
   } exp_t;

   exp_t rd_q[$];
   exp_t wr_q[$];

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   always @(posedge tb_clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   function automatic logic [6:0] ctrl_outs();
      return {o_cnt1_src, o_cnt1_count_up, o_cnt1_reload, o_cnt1_en,
              o_cnt0_count_up, o_cnt0_reload, o_cnt0_en};
   endfunction

   // Presents AW/W (W leading AW by w_lead cycles), pushes the expected bresp,
   // and optionally pulses i_cnt1_done on the commit edge.
   task automatic send_aw_w(input logic [5:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int w_lead,
                            input logic [1:0] exp_resp, input bit pulse1,
                            output int aw_edge);
      exp_t e;
      bit   aw_done, w_done, aw_fire, w_fire;
      int   lead, guard;
      e.data = 32'h0;
      e.resp = exp_resp;
      wr_q.push_back(e);
      aw_done = 1'b0;
      w_done  = 1'b0;
      lead    = w_lead;
      guard   = 0;
      aw_edge = 0;
      s_axi.wdata  = data;
      s_axi.wstrb  = strb;
      s_axi.wvalid = 1'b1;
      s_axi.awaddr = addr;
      if (lead == 0) s_axi.awvalid = 1'b1;
      while (!(aw_done && w_done) && guard < 100) begin
         @(negedge tb_clk);
         aw_fire = s_axi.awvalid && s_axi.awready;
         w_fire  = s_axi.wvalid && s_axi.wready;
         @(posedge tb_clk);
         #1;
         guard++;
         if (aw_fire) begin
            aw_done       = 1'b1;
            s_axi.awvalid = 1'b0;
            aw_edge       = cyc;
         end
         if (w_fire) begin
            w_done       = 1'b1;
            s_axi.wvalid = 1'b0;
         end
         if (!aw_done && !s_axi.awvalid) begin
            if (lead > 0) lead--;
            if (lead == 0) s_axi.awvalid = 1'b1;
         end
      end
      if (!(aw_done && w_done)) check_val("aw_w_handshake_timeout", 32'd0, 32'd1);
      s_axi.awvalid = 1'b0;
      s_axi.wvalid  = 1'b0;
      if (pulse1) begin
         i_cnt1_done = 1'b1;
         @(posedge tb_clk);
         #1;
         i_cnt1_done = 1'b0;
      end
   endtask

   task automatic wait_b(input string tag, output int seen_cyc);
      exp_t e;
      int   guard;
      guard = 0;
      @(negedge tb_clk);
      while (!s_axi.bvalid && guard < 100) begin
         @(negedge tb_clk);
         guard++;
      end
      seen_cyc = cyc;
      e = wr_q.pop_front();
      if (!s_axi.bvalid) begin
         check_val({tag, "_bvalid_timeout"}, 32'd0, 32'd1);
      end else begin
         check_val({tag, "_bresp"}, 32'(s_axi.bresp), 32'(e.resp));
      end
      s_axi.bready = 1'b1;
      @(posedge tb_clk);
      #1;
   endtask

   task automatic send_ar(input logic [5:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp);
      exp_t e;
      bit   fire;
      int   guard;
      e.data = exp_data;
      e.resp = exp_resp;
      rd_q.push_back(e);
      s_axi.araddr  = addr;
      s_axi.arvalid = 1'b1;
      fire  = 1'b0;
      guard = 0;
      while (!fire && guard < 100) begin
         @(negedge tb_clk);
         fire = s_axi.arready;
         @(posedge tb_clk);
         #1;
         guard++;
      end
      if (!fire) check_val("ar_handshake_timeout", 32'd0, 32'd1);
      s_axi.arvalid = 1'b0;
   endtask

   task automatic wait_r(input string tag);
      exp_t e;
      int   guard;
      guard = 0;
      @(negedge tb_clk);
      while (!s_axi.rvalid && guard < 100) begin
         @(negedge tb_clk);
         guard++;
      end
      e = rd_q.pop_front();
      if (!s_axi.rvalid) begin
         check_val({tag, "_rvalid_timeout"}, 32'd0, 32'd1);
      end else begin
         check_val({tag, "_rdata"}, s_axi.rdata, e.data);
         check_val({tag, "_rresp"}, 32'(s_axi.rresp), 32'(e.resp));
      end
      s_axi.rready = 1'b1;
      @(posedge tb_clk);
      #1;
   endtask

   task automatic axi_write(input string tag, input logic [5:0] addr,
                            input logic [31:0] data, input logic [3:0] strb,
                            input logic [1:0] exp_resp);
      int h, s;
      send_aw_w(addr, data, strb, 0, exp_resp, 1'b0, h);
      wait_b(tag, s);
   endtask

   task automatic axi_read(input string tag, input logic [5:0] addr,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp);
      send_ar(addr, exp_data, exp_resp);
      wait_r(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, required $finish earlier");
      $fatal(1);
   end

   initial begin
      int h, s;
      rst_n         = 1'b0;
      s_axi.awaddr  = '0;
      s_axi.awvalid = 1'b0;
      s_axi.wdata   = '0;
      s_axi.wstrb   = '0;
      s_axi.wvalid  = 1'b0;
      s_axi.bready  = 1'b1;
      s_axi.araddr  = '0;
      s_axi.arvalid = 1'b0;
      s_axi.rready  = 1'b1;
      i_cnt0_done   = 1'b0;
      i_cnt1_done   = 1'b0;
      i_cnt0_value  = 32'h0;
      i_cnt1_value  = 32'h0;

      // Reset and the first cycle after release.
      repeat (3) @(posedge tb_clk);
      @(negedge tb_clk);
      check_val("rst_awready", 32'(s_axi.awready), 32'd0);
      check_val("rst_irq", 32'(o_irq), 32'd0);
      @(posedge tb_clk);
      #1;
      rst_n = 1'b1;
      @(negedge tb_clk);
      check_val("post_rst_readies", 32'({s_axi.awready, s_axi.wready, s_axi.arready}), 32'd0);
      check_val("post_rst_bvalid_rvalid", 32'({s_axi.bvalid, s_axi.rvalid}), 32'd0);
      check_val("post_rst_ctrl_outs", 32'(ctrl_outs()), 32'd0);
      check_val("post_rst_cmp0", o_cnt0_compare_value, 32'd0);
      @(posedge tb_clk);
      #1;
      @(negedge tb_clk);
      check_val("readies_up", 32'({s_axi.awready, s_axi.wready, s_axi.arready}), 32'h7);
      @(posedge tb_clk);
      #1;

      for (int i = 0; i <= 8; i++) begin
         axi_read($sformatf("rst_read_%0d", i), 6'(i * 4), 32'h0, 2'b00);
      end

      // Configuration writes and readback.
      i_cnt0_value = 32'h1234_5678;
      i_cnt1_value = 32'hCAFE_0001;
      axi_write("ctrl_all_ones", 6'h00, 32'hFFFF_FFFF, 4'hF, 2'b00);
      axi_read("ctrl_mask_rb", 6'h00, 32'h0000_0F07, 2'b00);
      axi_write("ctrl_f07", 6'h00, 32'h0000_0F07, 4'hF, 2'b00);
      check_val("ctrl_outs", 32'(ctrl_outs()), 32'h7F);
      axi_write("cmp0", 6'h08, 32'd100, 4'hF, 2'b00);
      check_val("cmp0_out", o_cnt0_compare_value, 32'd100);
      axi_write("cmp1", 6'h10, 32'd5, 4'hF, 2'b00);
      check_val("cmp1_out", o_cnt1_compare_value, 32'd5);
      axi_read("cmp0_rb", 6'h08, 32'd100, 2'b00);
      axi_read("cmp1_rb", 6'h13, 32'd5, 2'b00);
      axi_read("val0", 6'h14, 32'h1234_5678, 2'b00);
      axi_read("val1", 6'h18, 32'hCAFE_0001, 2'b00);

      // Write strobes.
      axi_write("load0_strb", 6'h04, 32'hAABB_CCDD, 4'b0101, 2'b00);
      axi_read("load0_strb_rb", 6'h04, 32'h00BB_00DD, 2'b00);
      check_val("load0_out", o_cnt0_load_value, 32'h00BB_00DD);
      axi_write("load1_strb", 6'h0C, 32'hAABB_CCDD, 4'b1010, 2'b00);
      axi_read("load1_strb_rb", 6'h0C, 32'hAA00_CC00, 2'b00);

      // W leads AW by three cycles: one response, one cycle after AW.
      send_aw_w(6'h0C, 32'h5555_AAAA, 4'hF, 3, 2'b00, 1'b0, h);
      wait_b("w_first", s);
      check_val("w_first_latency", 32'(s), 32'(h + 1));
      @(negedge tb_clk);
      check_val("w_first_single_bvalid", 32'(s_axi.bvalid), 32'd0);
      @(posedge tb_clk);
      #1;
      axi_read("w_first_rb", 6'h0C, 32'h5555_AAAA, 2'b00);

      // Read-only and unmapped offsets.
      axi_write("ro_write", 6'h14, 32'hFFFF_FFFF, 4'hF, 2'b00);
      axi_read("ro_rb", 6'h14, 32'h1234_5678, 2'b00);
      axi_write("unmapped_wr", 6'h3C, 32'hFFFF_FFFF, 4'hF, 2'b10);
      axi_read("unmapped_rd", 6'h3C, 32'h0, 2'b10);
      axi_read("ctrl_after_err", 6'h00, 32'h0000_0F07, 2'b00);

      // Interrupts.
      axi_write("irq_en", 6'h20, 32'h1, 4'hF, 2'b00);
      i_cnt0_done = 1'b1;
      i_cnt1_done = 1'b1;
      @(posedge tb_clk);
      #1;
      i_cnt0_done = 1'b0;
      i_cnt1_done = 1'b0;
      @(negedge tb_clk);
      check_val("irq_latency_low", 32'(o_irq), 32'd0);
      @(negedge tb_clk);
      check_val("irq_high", 32'(o_irq), 32'd1);
      @(posedge tb_clk);
      #1;
      axi_read("status_3", 6'h1C, 32'h3, 2'b00);
      axi_write("w1c_bit0", 6'h1C, 32'h1, 4'hF, 2'b00);
      check_val("irq_cleared", 32'(o_irq), 32'd0);
      axi_read("status_2", 6'h1C, 32'h2, 2'b00);
      axi_write("w1c_no_lane0", 6'h1C, 32'h2, 4'b1110, 2'b00);
      axi_read("status_kept", 6'h1C, 32'h2, 2'b00);
      send_aw_w(6'h1C, 32'h2, 4'hF, 0, 2'b00, 1'b1, h);
      wait_b("w1c_vs_set", s);
      axi_read("status_set_wins", 6'h1C, 32'h2, 2'b00);
      axi_write("w1c_bit1", 6'h1C, 32'h2, 4'hF, 2'b00);
      axi_read("status_0", 6'h1C, 32'h0, 2'b00);

      // Backpressure on both response channels.
      s_axi.bready = 1'b0;
      s_axi.rready = 1'b0;
      send_aw_w(6'h3C, 32'h1, 4'hF, 0, 2'b10, 1'b0, h);
      send_ar(6'h08, 32'd100, 2'b00);
      for (int i = 0; i < 10; i++) begin
         @(negedge tb_clk);
         check_val("bp_bvalid", 32'(s_axi.bvalid), 32'd1);
         check_val("bp_bresp", 32'(s_axi.bresp), 32'h2);
         check_val("bp_aw_w_ready", 32'({s_axi.awready, s_axi.wready}), 32'd0);
         check_val("bp_rvalid", 32'(s_axi.rvalid), 32'd1);
         check_val("bp_rresp", 32'(s_axi.rresp), 32'd0);
         check_val("bp_rdata", s_axi.rdata, 32'd100);
      end
      @(posedge tb_clk);
      #1;
      wait_b("bp_write", s);
      wait_r("bp_read");
      @(negedge tb_clk);
      check_val("bp_ready_back", 32'({s_axi.awready, s_axi.wready}), 32'h3);

      // Asynchronous reset clears registers immediately.
      #1;
      rst_n = 1'b0;
      #1;
      check_val("async_rst_ctrl", 32'(ctrl_outs()), 32'd0);
      check_val("async_rst_cmp1", o_cnt1_compare_value, 32'd0);
      check_val("async_rst_awready", 32'(s_axi.awready), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
